// File: rtl/zephyr_core_p.sv
// zephyr_core_p: multicycle accumulator core (FETCH/DECODE/EXECUTE/HALT)
// driving an external single-port RAM with one-cycle read latency.
module zephyr_core_p #(
    parameter int          DW       = 8,
    parameter int          AW       = DW - 4,
    parameter int unsigned RESET_PC = 0
) (
    input  logic          CLK,
    input  logic          RESET,
    output logic [AW-1:0] RAM_ADDR,
    input  logic [DW-1:0] RAM_RDATA,
    output logic [DW-1:0] RAM_WDATA,
    output logic          RAM_WE,
    output logic [1:0]    STATE,
    output logic [AW-1:0] PC,
    output logic [DW-1:0] IR,
    output logic [DW-1:0] ACC,
    output logic          FLAG_Z,
    output logic          FLAG_C,
    output logic          HALTED
);

    typedef enum logic [1:0] {
        S_FETCH  = 2'b00,
        S_DECODE = 2'b01,
        S_EXEC   = 2'b10,
        S_HALT   = 2'b11
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_LOAD = 4'h4;
    localparam logic [3:0] OP_ST   = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_JZ   = 4'h7;
    localparam logic [3:0] OP_JC   = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t        state;
    logic [3:0]    op;
    logic [AW-1:0] opnd;
    logic [DW:0]   sum;
    logic [DW:0]   diff;
    logic [DW-1:0] acc_nx;
    logic          c_nx;
    logic          acc_we;
    logic          jump;

    assign op   = IR[DW-1:DW-4];
    assign opnd = IR[AW-1:0];
    assign sum  = {1'b0, ACC} + {1'b0, RAM_RDATA};
    // MSB of the widened difference is set exactly when ACC < M
    assign diff = {1'b0, ACC} - {1'b0, RAM_RDATA};

    assign jump = (op == OP_JMP)
                | ((op == OP_JZ) & FLAG_Z)
                | ((op == OP_JC) & FLAG_C);

    always_comb begin
        acc_we = 1'b0;
        acc_nx = ACC;
        c_nx   = FLAG_C;
        case (op)
            OP_LDI: begin
                acc_we = 1'b1;
                acc_nx = DW'(opnd);
            end
            OP_ADD: begin
                acc_we = 1'b1;
                {c_nx, acc_nx} = sum;
            end
            OP_SUB: begin
                acc_we = 1'b1;
                acc_nx = diff[DW-1:0];
                c_nx   = diff[DW];
            end
            OP_LOAD: begin
                acc_we = 1'b1;
                acc_nx = RAM_RDATA;
            end
            default: ;
        endcase
    end

    // DECODE forwards the arriving operand so M is ready in EXECUTE
    always_comb begin
        RAM_ADDR = opnd;
        unique case (state)
            S_FETCH:  RAM_ADDR = PC;
            S_DECODE: RAM_ADDR = RAM_RDATA[AW-1:0];
            default:  RAM_ADDR = opnd;
        endcase
    end

    assign RAM_WDATA = ACC;
    assign RAM_WE    = (state == S_EXEC) && (op == OP_ST);
    assign STATE     = state;
    assign HALTED    = (state == S_HALT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= S_FETCH;
            PC     <= AW'(RESET_PC);
            IR     <= '0;
            ACC    <= '0;
            FLAG_Z <= 1'b0;
            FLAG_C <= 1'b0;
        end else begin
            unique case (state)
                S_FETCH: state <= S_DECODE;
                S_DECODE: begin
                    IR    <= RAM_RDATA;
                    PC    <= PC + AW'(1);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    if (acc_we) begin
                        ACC    <= acc_nx;
                        FLAG_Z <= (acc_nx == '0);
                        FLAG_C <= c_nx;
                    end
                    if (jump) PC <= opnd;
                    state <= (op == OP_HALT) ? S_HALT : S_FETCH;
                end
                S_HALT: state <= S_HALT;
            endcase
        end
    end

endmodule
